// File: rtl/prog_instr_mem.sv
// Run-time loadable instruction memory: a byte-stream loader packs MSB-first bytes into
// instruction words, and a registered fetch port returns NOP past the loaded program end.
module prog_instr_mem #(
  parameter int ADDR_W    = 11,
  parameter int INSTR_W   = 17,
  parameter int NOP_INSTR = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic [7:0]        load_byte,
  input  logic              load_valid,
  input  logic              load_last,
  output logic              load_ready,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   prog_len,
  output logic              busy,
  input  logic              read_en,
  input  logic [ADDR_W-1:0] addr,
  output logic [INSTR_W-1:0] instr_out,
  output logic              instr_valid
);

  localparam int BPI   = (INSTR_W + 7) / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int AW    = BPI * 8;
  localparam int BIW   = $clog2(BPI + 1);
  localparam logic [BIW-1:0]     LAST_IDX = BIW'(BPI - 1);
  localparam logic [INSTR_W-1:0] NOP_W    = INSTR_W'(NOP_INSTR);

  localparam logic [1:0] SEL_ZERO = 2'd0;
  localparam logic [1:0] SEL_RAM  = 2'd1;
  localparam logic [1:0] SEL_NOP  = 2'd2;

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [AW-1:0]       asm_q, asm_d;
  logic [BIW-1:0]      byte_idx_q, byte_idx_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W:0]     prog_len_q, prog_len_d;
  logic                load_err_q, load_err_d;
  logic [1:0]          sel_q, sel_d;
  logic                instr_valid_q, instr_valid_d;

  logic                xfer;
  logic                fetch;
  logic                hit;
  logic                wr_en;
  logic [AW-1:0]       asm_shift;
  logic [INSTR_W-1:0]  wr_data;
  logic [INSTR_W-1:0]  ram_rd;
  logic [INSTR_W-1:0]  ram [DEPTH];

  generate
    if (BPI == 1) begin : g_asm1
      assign asm_shift = load_byte;
    end else begin : g_asmn
      assign asm_shift = {asm_q[AW-9:0], load_byte};
    end
  endgenerate

  assign xfer    = load_valid && (state_q == S_LOAD);
  assign fetch   = read_en && (state_q != S_LOAD);
  assign hit     = ({1'b0, addr} < prog_len_q);
  assign wr_data = asm_shift[INSTR_W-1:0];

  always_comb begin
    state_d       = state_q;
    asm_d         = asm_q;
    byte_idx_d    = byte_idx_q;
    wr_addr_d     = wr_addr_q;
    prog_len_d    = prog_len_q;
    load_err_d    = load_err_q;
    sel_d         = sel_q;
    instr_valid_d = fetch;
    wr_en         = 1'b0;

    // Fetch uses the pre-load prog_len even when a load starts on the same edge.
    if (fetch) begin
      sel_d = hit ? SEL_RAM : SEL_NOP;
    end

    case (state_q)
      S_IDLE: begin
        if (load_start) begin
          state_d    = S_LOAD;
          asm_d      = '0;
          byte_idx_d = '0;
          wr_addr_d  = '0;
          prog_len_d = '0;
          load_err_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (xfer) begin
          asm_d = asm_shift;
          if (byte_idx_q == LAST_IDX) begin
            wr_en      = 1'b1;
            wr_addr_d  = wr_addr_q + ADDR_W'(1);
            prog_len_d = prog_len_q + (ADDR_W + 1)'(1);
            byte_idx_d = '0;
            if (load_last) begin
              state_d = S_DONE;
            end else if (&wr_addr_q) begin
              // Memory full with no terminator: stop accepting and flag overflow.
              state_d    = S_DONE;
              load_err_d = 1'b1;
            end
          end else begin
            byte_idx_d = byte_idx_q + BIW'(1);
            if (load_last) begin
              state_d    = S_DONE;
              load_err_d = 1'b1;
            end
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      asm_q         <= '0;
      byte_idx_q    <= '0;
      wr_addr_q     <= '0;
      prog_len_q    <= '0;
      load_err_q    <= 1'b0;
      sel_q         <= SEL_ZERO;
      instr_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      asm_q         <= asm_d;
      byte_idx_q    <= byte_idx_d;
      wr_addr_q     <= wr_addr_d;
      prog_len_q    <= prog_len_d;
      load_err_q    <= load_err_d;
      sel_q         <= sel_d;
      instr_valid_q <= instr_valid_d;
    end
  end

  // Array has no reset so it maps onto block RAM; the read register only moves on a fetch.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      ram[wr_addr_q] <= wr_data;
    end
    if (fetch) begin
      ram_rd <= ram[addr];
    end
  end

  always_comb begin
    instr_out = '0;
    case (sel_q)
      SEL_RAM: instr_out = ram_rd;
      SEL_NOP: instr_out = NOP_W;
      default: instr_out = '0;
    endcase
  end

  assign load_ready  = (state_q == S_LOAD);
  assign busy        = (state_q == S_LOAD);
  assign load_done   = (state_q == S_DONE);
  assign load_err    = load_err_q;
  assign prog_len    = prog_len_q;
  assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_prog_instr_mem.sv
// Directed and randomized checks of prog_instr_mem against a word-list model built from
// the byte stream that was offered to the loader.
module tb_prog_instr_mem;

  logic        clk = 1'b0;
  logic        rst;
  logic        load_start;
  logic [7:0]  load_byte;
  logic        load_valid;
  logic        load_last;
  logic        load_ready;
  logic        load_done;
  logic        load_err;
  logic [11:0] prog_len;
  logic        busy;
  logic        read_en;
  logic [10:0] addr;
  logic [16:0] instr_out;
  logic        instr_valid;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]  prog_q[$];
  logic [16:0] m_mem [2048];
  int          m_len;
  bit          m_err;

  prog_instr_mem dut (
    .clk(clk), .rst(rst), .load_start(load_start), .load_byte(load_byte),
    .load_valid(load_valid), .load_last(load_last), .load_ready(load_ready),
    .load_done(load_done), .load_err(load_err), .prog_len(prog_len), .busy(busy),
    .read_en(read_en), .addr(addr), .instr_out(instr_out), .instr_valid(instr_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [16:0] model_fetch(input int a);
    return (a < m_len) ? m_mem[a] : 17'd28;
  endfunction

  task automatic do_fetch(input int a);
    logic [16:0] e;
    e = model_fetch(a);
    read_en = 1'b1;
    addr    = 11'(a);
    tick();
    read_en = 1'b0;
    chk("fetch_valid", instr_valid, 1);
    chk("fetch_data", instr_out, e);
    tick();
    chk("hold_valid", instr_valid, 0);
    chk("hold_data", instr_out, e);
    $display("fetch addr=%0d instr=%05h expected=%05h", a, instr_out, e);
  endtask

  task automatic send_prog(input bit last_at_end, input bit hold_rd,
                           input bit start_fetch, input int faddr);
    int n, nb, full, exp_n;
    logic [16:0] exp_f, held;
    logic [23:0] w;
    exp_f = model_fetch(faddr);
    load_start = 1'b1;
    if (start_fetch) begin
      read_en = 1'b1;
      addr    = 11'(faddr);
    end
    tick();
    load_start = 1'b0;
    read_en    = 1'b0;
    if (start_fetch) begin
      chk("startfetch_valid", instr_valid, 1);
      chk("startfetch_data", instr_out, exp_f);
    end
    chk("load_busy", busy, 1);
    chk("load_ready", load_ready, 1);
    if (hold_rd) begin
      read_en = 1'b1;
      addr    = 11'd0;
    end
    held = instr_out;
    n = 0;
    for (int i = 0; i < prog_q.size(); i++) begin
      if (!load_ready) break;
      load_byte  = prog_q[i];
      load_valid = 1'b1;
      load_last  = last_at_end && (i == prog_q.size() - 1);
      tick();
      load_valid = 1'b0;
      load_last  = 1'b0;
      n++;
      if (hold_rd) begin
        chk("busyfetch_valid", instr_valid, 0);
        chk("busyfetch_hold", instr_out, held);
      end
    end
    read_en = 1'b0;

    nb   = prog_q.size();
    full = nb / 3;
    if (full >= 2048 && !(last_at_end && nb == 6144)) begin
      m_len = 2048;
      m_err = 1'b1;
      exp_n = 6144;
    end else begin
      m_len = full;
      m_err = (nb % 3 != 0) || !last_at_end;
      exp_n = nb;
    end
    for (int k = 0; k < m_len; k++) begin
      w = {prog_q[3*k], prog_q[3*k+1], prog_q[3*k+2]};
      m_mem[k] = w[16:0];
    end

    chk("bytes_accepted", n, exp_n);
    chk("done_pulse", load_done, 1);
    chk("done_err", load_err, m_err);
    chk("done_len", prog_len, m_len);
    chk("done_ready", load_ready, 0);
    chk("done_busy", busy, 0);
    $display("load bytes=%0d accepted=%0d prog_len=%0d err=%0b", nb, n, prog_len, load_err);
    tick();
    chk("done_one_cycle", load_done, 0);
    chk("err_sticky", load_err, m_err);
  endtask

  initial begin
    rst        = 1'b1;
    load_start = 1'b0;
    load_byte  = 8'h00;
    load_valid = 1'b0;
    load_last  = 1'b0;
    read_en    = 1'b0;
    addr       = '0;
    m_len      = 0;
    m_err      = 1'b0;
    tick();
    tick();
    chk("rst_instr_out", instr_out, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_len", prog_len, 0);
    chk("rst_err", load_err, 0);
    chk("rst_done", load_done, 0);
    chk("rst_ready", load_ready, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    tick();
    do_fetch(3);

    // Directed three-word program.
    prog_q = '{8'h00, 8'h50, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h1C};
    send_prog(1'b1, 1'b0, 1'b0, 0);
    chk("dir_w0", m_mem[0], 17'h05000);
    chk("dir_w1", m_mem[1], 17'h01300);
    chk("dir_w2", m_mem[2], 17'h0001C);
    do_fetch(0);
    do_fetch(1);
    do_fetch(2);
    do_fetch(5);

    // Terminator on the second byte of word 1.
    prog_q = '{8'h01, 8'h23, 8'h45, 8'h67, 8'h89};
    send_prog(1'b1, 1'b0, 1'b0, 0);
    do_fetch(0);
    do_fetch(1);

    // Fetch held throughout a load, then a fetch coinciding with load_start.
    prog_q = '{8'hFF, 8'hAA, 8'h55, 8'h12, 8'h34, 8'h56};
    send_prog(1'b1, 1'b1, 1'b0, 0);
    do_fetch(0);
    do_fetch(1);
    prog_q = '{8'h00, 8'h00, 8'h07};
    send_prog(1'b1, 1'b0, 1'b1, 1);
    do_fetch(0);
    do_fetch(1);

    // Randomized programs, some truncated mid-word.
    for (int r = 0; r < 8; r++) begin
      int words, cut;
      words = $urandom_range(1, 24);
      cut   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 2) : 0;
      prog_q.delete();
      for (int b = 0; b < words * 3 - cut; b++) prog_q.push_back(8'($urandom));
      send_prog(1'b1, 1'b0, ($urandom_range(0, 1) == 1), $urandom_range(0, 30));
      for (int f = 0; f < 6; f++) do_fetch($urandom_range(0, words + 3));
    end

    // Reset part-way through a load after four words.
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    for (int b = 0; b < 12; b++) begin
      load_byte  = 8'($urandom);
      load_valid = 1'b1;
      tick();
    end
    load_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_len", prog_len, 0);
    chk("midrst_ready", load_ready, 0);
    chk("midrst_valid", instr_valid, 0);
    chk("midrst_out", instr_out, 0);
    #2 rst = 1'b0;
    m_len = 0;
    tick();
    do_fetch(0);
    do_fetch(3);

    // Overflow: 2049 words offered with no terminator.
    prog_q.delete();
    for (int b = 0; b < 2049 * 3; b++) prog_q.push_back(8'($urandom));
    send_prog(1'b0, 1'b0, 1'b0, 0);
    do_fetch(0);
    do_fetch(1000);
    do_fetch(2047);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
